if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, address of first fetch after reset.
REQ-002 Parameter NOP_WORD, 32'h0000_0000, instruction word loaded into IF/ID on bubble or flush.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 imem_req  out  1  fetch request to instruction memory.
REQ-006 imem_addr  out  32  fetch address (current PC).
REQ-007 imem_ready  in  1  imem_rdata valid for imem_addr this cycle.
REQ-008 imem_rdata  in  32  fetched instruction word.
REQ-009 stall_d  in  1  decode stage stalled; hold PC and IF/ID.
REQ-010 branch_taken  in  1  resolved BEQ/BNE taken in decode.
REQ-011 branch_target  in  32  branch destination.
REQ-012 jump  in  1  decoded J in decode.
REQ-013 jump_target  in  32  jump destination.
REQ-014 instr_d  out  32  IF/ID instruction word.
REQ-015 op_d  out  6  instr_d[31:26], feeds main decoder opcode input.
REQ-016 pcplus4_d  out  32  IF/ID PC+4 of instr_d.
REQ-017 valid_d  out  1  instr_d is a real fetched instruction.

Function
REQ-018 FSM states BOOT, RUN; BOOT lasts exactly one cycle after reset release, then RUN permanently.
REQ-019 BOOT: imem_req=0, PC held at RESET_PC, IF/ID holds bubble.
REQ-020 RUN: imem_req=1 every cycle; imem_addr=PC combinationally.
REQ-021 Redirect = jump | branch_taken; target priority jump > branch_taken (jump_target wins if both high).
REQ-022 Redirect in RUN: PC <= target next edge, IF/ID <= bubble (instr_d=NOP_WORD, valid_d=0, pcplus4_d=0), regardless of stall_d and imem_ready.
REQ-023 No redirect, stall_d=1: PC and IF/ID hold; fetched word discarded.
REQ-024 No redirect, stall_d=0, imem_ready=1: PC <= PC+4; IF/ID <= {imem_rdata, PC+4}, valid_d=1.
REQ-025 No redirect, stall_d=0, imem_ready=0: PC holds; IF/ID <= bubble.
REQ-026 PC+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000 with no flag.
REQ-027 PC[1:0] always 2'b00; targets with nonzero [1:0] are forced to 00 before load.
REQ-028 op_d is a pure slice of instr_d; bubble gives op_d=6'b000000 (R-type NOP, no side effects).
REQ-029 Fetch-to-IF/ID latency: one cycle from imem_ready sample to instr_d.
REQ-030 Redirect inputs ignored in BOOT.

Reset
REQ-031 reset_n low asynchronously sets: state=BOOT, PC=RESET_PC, instr_d=NOP_WORD, pcplus4_d=0, valid_d=0, imem_req=0.
REQ-032 Reset asserted mid-fetch aborts in-flight word; no IF/ID update from it.
REQ-033 Reset release synchronous to clk edge; first RUN fetch address is RESET_PC.

Structure
REQ-034 Shared package mips_pkg holds RESET_PC default, NOP_WORD, opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI, OP_J), fetch state enum.
REQ-035 Sub-module flopenr (enable flop, async active-low reset, parameter width and reset value) instantiated for PC and IF/ID fields.
REQ-036 Next-PC mux and FSM stay in if_stage.

Verification
REQ-037 Reset then imem_ready=1, stall_d=0, sequential words 0x20080005, 0x8D090004 -> imem_addr 0x0,0x4,0x8; instr_d shows each one cycle later, op_d 6'b001000 then 6'b100011.
REQ-038 At PC=0x10, stall_d=1 for 3 cycles -> PC stays 0x10, instr_d/valid_d unchanged, resumes 0x14 after release.
REQ-039 branch_taken=1, branch_target=0x40, jump=0 -> next imem_addr 0x40, valid_d=0 one cycle; same with stall_d=1 -> identical result.
REQ-040 jump=1 (0x100) and branch_taken=1 (0x40) same cycle -> imem_addr 0x100.
REQ-041 imem_ready=0 two cycles at PC=0x8 -> PC holds 0x8, valid_d=0, op_d=0; word fetched when ready returns.
REQ-042 PC=0xFFFF_FFFC fetch -> next PC 0x0, pcplus4_d 0x0; reset_n pulsed mid-stream -> all outputs at reset values immediately, one BOOT cycle, then fetch at 0x0.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared fetch-stage constants, opcodes and fetch state enum.
package mips_pkg;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_J = 6'b000010;
  typedef enum logic {BOOT, RUN} fetch_state_t;
endpackage

// File: rtl/flopenr.sv
// flopenr: enable flop with asynchronous active-low reset to a parameterised value.
module flopenr #(
  parameter int W = 32,
  parameter logic [W-1:0] RV = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) q <= RV;
    else if (en) q <= d;
endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch with PC register, redirect mux and IF/ID pipeline register.
module if_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_WORD = mips_pkg::NOP_WORD
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall_d,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] instr_d,
  output logic [5:0]  op_d,
  output logic [31:0] pcplus4_d,
  output logic        valid_d
);
  fetch_state_t state;
  logic [31:0] pc, pc4, tgt, pc_next, instr_next, pc4_next;
  logic run, redirect, take, bubble, pc_en, ifid_en, valid_next;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= BOOT;
      imem_req <= 1'b0;
    end else begin
      state <= RUN;
      imem_req <= 1'b1;
    end
  // Redirects are squashed in BOOT; jump outranks a taken branch.
  always_comb begin
    run = state == RUN;
    redirect = run & (jump | branch_taken);
    take = !stall_d & imem_ready;
    bubble = redirect | !imem_ready;
    pc4 = pc + 32'd4;
    tgt = (jump ? jump_target : branch_target) & ~32'd3;
    pc_next = redirect ? tgt : pc4;
    pc_en = redirect | (run & take);
    ifid_en = redirect | (run & !stall_d);
    instr_next = bubble ? NOP_WORD : imem_rdata;
    pc4_next = bubble ? 32'd0 : pc4;
    valid_next = !bubble;
  end
  flopenr #(.W(32), .RV(RESET_PC)) pc_reg (.clk, .reset_n, .en(pc_en), .d(pc_next), .q(pc));
  flopenr #(.W(32), .RV(NOP_WORD)) instr_reg (.clk, .reset_n, .en(ifid_en), .d(instr_next), .q(instr_d));
  flopenr #(.W(32), .RV(32'd0)) pc4_reg (.clk, .reset_n, .en(ifid_en), .d(pc4_next), .q(pcplus4_d));
  flopenr #(.W(1), .RV(1'b0)) valid_reg (.clk, .reset_n, .en(ifid_en), .d(valid_next), .q(valid_d));
  assign imem_addr = pc;
  assign op_d = instr_d[31:26];
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed vector table, reset corner sequence and randomized run against a rule-level model.
module tb_if_stage;
  import mips_pkg::*;
  logic clk = 0, reset_n = 0;
  logic imem_req, imem_ready = 0, stall_d = 0, branch_taken = 0, jump = 0, valid_d;
  logic [31:0] imem_addr, imem_rdata = 0, branch_target = 0, jump_target = 0, instr_d, pcplus4_d;
  logic [5:0] op_d;
  int vectors = 0, miscompares = 0;
  always #5 clk = ~clk;
  if_stage dut (
    .clk(clk), .reset_n(reset_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .stall_d(stall_d),
    .branch_taken(branch_taken), .branch_target(branch_target), .jump(jump),
    .jump_target(jump_target), .instr_d(instr_d), .op_d(op_d),
    .pcplus4_d(pcplus4_d), .valid_d(valid_d)
  );
  typedef struct {
    logic stall, br, jmp, rdy;
    logic [31:0] bt, jt, e_addr, e_instr, e_pc4;
    logic e_valid;
  } vec_t;
  vec_t tbl[18];
  function automatic logic [31:0] word(input logic [31:0] a);
    return a == 32'h0 ? 32'h2008_0005 : a == 32'h4 ? 32'h8D09_0004 : 32'hAC00_0000 | a;
  endfunction
  function automatic vec_t mk(input logic s, b, j, r, input logic [31:0] bt, jt, ea, ei, ep, input logic ev);
    vec_t v;
    v.stall = s; v.br = b; v.jmp = j; v.rdy = r; v.bt = bt; v.jt = jt;
    v.e_addr = ea; v.e_instr = ei; v.e_pc4 = ep; v.e_valid = ev;
    return v;
  endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  task automatic chk_all(input string n, input logic req, input logic [31:0] addr, instr, pc4, input logic v);
    chk({n, ".req"}, {31'd0, imem_req}, {31'd0, req});
    chk({n, ".addr"}, imem_addr, addr);
    chk({n, ".instr"}, instr_d, instr);
    chk({n, ".op"}, {26'd0, op_d}, {26'd0, instr[31:26]});
    chk({n, ".pc4"}, pcplus4_d, pc4);
    chk({n, ".valid"}, {31'd0, valid_d}, {31'd0, v});
  endtask
  initial begin
    logic [31:0] cur, pc_m, instr_m, pc4_m, w;
    logic valid_m;
    tbl[0]  = mk(0, 1, 0, 1, 32'h40, 0, 32'h0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 1, 0, 0, 32'h4, 32'h2008_0005, 32'h4, 1);
    tbl[2]  = mk(0, 0, 0, 1, 0, 0, 32'h8, 32'h8D09_0004, 32'h8, 1);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 32'h8, 0, 0, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 32'h8, 0, 0, 0);
    tbl[5]  = mk(0, 0, 0, 1, 0, 0, 32'hC, word(32'h8), 32'hC, 1);
    tbl[6]  = mk(0, 0, 0, 1, 0, 0, 32'h10, word(32'hC), 32'h10, 1);
    tbl[7]  = mk(1, 0, 0, 1, 0, 0, 32'h10, word(32'hC), 32'h10, 1);
    tbl[8]  = mk(1, 0, 0, 1, 0, 0, 32'h10, word(32'hC), 32'h10, 1);
    tbl[9]  = mk(1, 0, 0, 0, 0, 0, 32'h10, word(32'hC), 32'h10, 1);
    tbl[10] = mk(0, 0, 0, 1, 0, 0, 32'h14, word(32'h10), 32'h14, 1);
    tbl[11] = mk(0, 1, 0, 1, 32'h40, 0, 32'h40, 0, 0, 0);
    tbl[12] = mk(0, 0, 0, 1, 0, 0, 32'h44, word(32'h40), 32'h44, 1);
    tbl[13] = mk(1, 1, 0, 1, 32'h40, 0, 32'h40, 0, 0, 0);
    tbl[14] = mk(0, 1, 1, 1, 32'h40, 32'h100, 32'h100, 0, 0, 0);
    tbl[15] = mk(0, 0, 1, 0, 0, 32'h203, 32'h200, 0, 0, 0);
    tbl[16] = mk(1, 0, 1, 1, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 0, 0);
    tbl[17] = mk(0, 0, 0, 1, 0, 0, 32'h0, word(32'hFFFF_FFFC), 32'h0, 1);
    repeat (2) @(posedge clk);
    #1 chk_all("reset", 0, 0, 0, 0, 0);
    @(negedge clk) reset_n = 1;
    #1 chk_all("boot", 0, 0, 0, 0, 0);
    cur = 0;
    foreach (tbl[i]) begin
      stall_d = tbl[i].stall; branch_taken = tbl[i].br; jump = tbl[i].jmp;
      imem_ready = tbl[i].rdy; branch_target = tbl[i].bt; jump_target = tbl[i].jt;
      imem_rdata = word(cur);
      @(posedge clk);
      #1 chk_all($sformatf("vec%0d", i), 1, tbl[i].e_addr, tbl[i].e_instr, tbl[i].e_pc4, tbl[i].e_valid);
      cur = tbl[i].e_addr;
    end
    stall_d = 0; branch_taken = 0; jump = 0; imem_ready = 1; imem_rdata = word(0);
    @(posedge clk);
    #2 reset_n = 0;
    #1 chk_all("rst_async", 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 chk_all("rst_hold", 0, 0, 0, 0, 0);
    @(negedge clk) reset_n = 1;
    branch_taken = 1; branch_target = 32'h80;
    @(posedge clk);
    #1 chk_all("rst_boot", 1, 0, 0, 0, 0);
    branch_taken = 0; imem_rdata = word(0);
    @(posedge clk);
    #1 chk_all("rst_fetch", 1, 32'h4, 32'h2008_0005, 32'h4, 1);
    pc_m = 32'h4; instr_m = 32'h2008_0005; pc4_m = 32'h4; valid_m = 1;
    for (int i = 0; i < 300; i++) begin
      stall_d = $urandom_range(0, 3) == 0;
      imem_ready = $urandom_range(0, 3) != 0;
      branch_taken = $urandom_range(0, 9) == 0;
      jump = $urandom_range(0, 11) == 0;
      branch_target = $urandom;
      jump_target = $urandom;
      w = $urandom;
      imem_rdata = w;
      if (jump || branch_taken) begin
        pc_m = (jump ? jump_target : branch_target);
        pc_m[1:0] = 2'b00;
        instr_m = NOP_WORD; pc4_m = 0; valid_m = 0;
      end else if (!stall_d) begin
        if (imem_ready) begin
          pc_m = pc_m + 4; instr_m = w; pc4_m = pc_m; valid_m = 1;
        end else begin
          instr_m = NOP_WORD; pc4_m = 0; valid_m = 0;
        end
      end
      @(posedge clk);
      #1 chk_all($sformatf("rnd%0d", i), 1, pc_m, instr_m, pc4_m, valid_m);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
